// File: rtl/dctq_pkg.sv
// rtl/dctq_pkg.sv - shared widths, sizing helper and round/saturate function for the DCT accumulator
// Purpose: default widths for the DCT MAC accumulator, a clog2 helper and the
//          rounding/saturation function applied to each completed sum.
// Ports:   none (package).
package dctq_pkg;

  localparam int PROD_W     = 19;
  localparam int OUT_W      = 12;
  localparam int N_TERMS    = 8;
  localparam int ACC_W      = 22;
  localparam int SHIFT      = 8;
  localparam int FIFO_DEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Returns {sat, value}. One guard bit above ACC_W keeps the rounding add
  // from wrapping when sum is at its positive extreme.
  function automatic logic [OUT_W:0] sat_round(input logic signed [ACC_W-1:0] sum,
                                               input int shift);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] r_max;
    logic signed [ACC_W:0] r_min;
    ext   = {sum[ACC_W-1], sum};
    half  = $signed((ACC_W+1)'(1) << (shift - 1));
    r     = (ext + half) >>> shift;
    r_max = $signed((ACC_W+1)'((1 << (OUT_W - 1)) - 1));
    r_min = $signed((ACC_W+1)'(-(1 << (OUT_W - 1))));
    if (r > r_max) begin
      return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end else if (r < r_min) begin
      return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end
    return {1'b0, r[OUT_W-1:0]};
  endfunction

endpackage

// File: rtl/dctq_sync_fifo.sv
// rtl/dctq_sync_fifo.sv - small synchronous FIFO with flush for the DCT output queue
// Purpose: DEPTH-entry first-word-fall-through queue; a push into a full queue
//          is accepted only when a pop happens on the same edge.
// Ports:   clk, rst_n (sync, active-low), flush (empties queue),
//          push/wdata, pop, rdata (head), full, empty, level (0..DEPTH).
module dctq_sync_fifo
  import dctq_pkg::*;
#(
  parameter int W     = OUT_W + 1,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [W-1:0]          wdata,
  input  logic                  pop,
  output logic [W-1:0]          rdata,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: contents are only visible while level is nonzero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dct_mac_accum.sv
// rtl/dct_mac_accum.sv - accumulates N_TERMS products into rounded, saturated DCT sums
// Purpose: sums groups of N_TERMS signed products, rounds/saturates each sum and
//          queues {sat, value} for a valid/ready consumer.
// Ports:   clk, rst_n (sync, active-low), prod_valid/prod_data (product input),
//          clear (flush), out_valid/out_ready/out_data/out_sat (queue head),
//          overflow (sticky drop flag), fifo_level (queue occupancy).
module dct_mac_accum
  import dctq_pkg::*;
#(
  parameter int N_TERMS_P    = N_TERMS,
  parameter int SHIFT_P      = SHIFT,
  parameter int FIFO_DEPTH_P = FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         prod_valid,
  input  logic [PROD_W-1:0]            prod_data,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_sat,
  output logic                         overflow,
  output logic [clog2(FIFO_DEPTH_P):0] fifo_level
);

  localparam int CNT_W = clog2(N_TERMS_P);

  logic [CNT_W-1:0]        term_cnt_q, term_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic                    sum_v_q, sum_v_d;
  logic                    overflow_q, overflow_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_next;
  logic                    last_term;
  logic [OUT_W:0]          rounded;
  logic [OUT_W:0]          head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    pop_ok;

  assign prod_ext  = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
  // First term of a group overwrites, so the accumulator never needs clearing.
  assign acc_next  = (term_cnt_q == '0) ? prod_ext : acc_q + prod_ext;
  assign last_term = (term_cnt_q == CNT_W'(N_TERMS_P - 1));
  assign rounded   = sat_round(sum_q, SHIFT_P);
  assign out_valid = !fifo_empty;
  assign pop_ok    = out_ready && out_valid;

  // Head is masked when empty so the outputs read zero out of reset and flush.
  assign out_sat   = out_valid ? head[OUT_W] : 1'b0;
  assign out_data  = out_valid ? head[OUT_W-1:0] : '0;
  assign overflow  = overflow_q;

  always_comb begin
    term_cnt_d = term_cnt_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    sum_v_d    = 1'b0;
    overflow_d = overflow_q;
    if (clear) begin
      term_cnt_d = '0;
      overflow_d = 1'b0;
    end else begin
      if (prod_valid) begin
        acc_d = acc_next;
        if (last_term) begin
          sum_d      = acc_next;
          sum_v_d    = 1'b1;
          term_cnt_d = '0;
        end else begin
          term_cnt_d = term_cnt_q + 1'b1;
        end
      end
      // A pop on the same edge frees the slot, so only a full, unpopped queue drops.
      if (sum_v_q && fifo_full && !pop_ok) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      term_cnt_q <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      sum_v_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      term_cnt_q <= term_cnt_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      sum_v_q    <= sum_v_d;
      overflow_q <= overflow_d;
    end
  end

  dctq_sync_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (FIFO_DEPTH_P)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (sum_v_q),
    .wdata (rounded),
    .pop   (out_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_dct_mac_accum.sv
// tb/tb_dct_mac_accum.sv - randomized self-checking bench for dct_mac_accum
module tb_dct_mac_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prod_valid = 1'b0;
  logic [18:0] prod_data = '0;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_sat;
  logic        overflow;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  int mq[$];
  int grp[$];
  bit pend_v = 1'b0;
  int pend_w = 0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  dct_mac_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_word(input longint s);
    longint r;
    r = (s + 64'sd128) >>> 8;
    if (r > 2047)  return 32'h17FF;
    if (r < -2048) return 32'h1800;
    return int'(r) & 32'hFFF;
  endfunction

  task automatic cmp_state();
    check_eq("out_valid", int'(out_valid), int'(mq.size() > 0));
    check_eq("fifo_level", int'(fifo_level), mq.size());
    check_eq("overflow", int'(overflow), int'(m_ovf));
    if (mq.size() > 0) check_eq("head", int'({out_sat, out_data}), mq[0]);
    else               check_eq("idle_out", int'({out_sat, out_data}), 0);
  endtask

  task automatic step(input bit pv, input int pd, input bit rdy, input bit clr, input bit rst);
    longint s;
    cmp_state();
    prod_valid = pv;
    prod_data  = 19'(pd);
    out_ready  = rdy;
    clear      = clr;
    rst_n      = !rst;
    @(posedge clk);
    if (rst || clr) begin
      mq.delete();
      grp.delete();
      pend_v = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (pend_v) begin
        if (mq.size() < 4) mq.push_back(pend_w);
        else m_ovf = 1'b1;
      end
      pend_v = 1'b0;
      if (pv) begin
        grp.push_back(pd);
        if (grp.size() == 8) begin
          s = 0;
          foreach (grp[i]) s += longint'(grp[i]);
          pend_w = ref_word(s);
          pend_v = 1'b1;
          grp.delete();
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 1000)), rdy, 1'b0, 1'b0);
  endtask

  task automatic group(input int first, input int rest, input bit rdy, input int gap);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 0) ? first : rest, rdy, 1'b0, 1'b0);
      if (i < 7) idle(gap, rdy);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Basic group, latency and value.
    group(100, 100, 1'b0, 0);
    check_eq("t1_lat_early", int'(out_valid), 0);
    idle(1, 1'b0);
    check_eq("t1_valid", int'(out_valid), 1);
    check_eq("t1_data", int'(out_data), 3);
    check_eq("t1_sat", int'(out_sat), 0);
    idle(2, 1'b1);

    // Rounding at the half-LSB boundary, with gaps inside the group.
    group(-128, 0, 1'b0, 1);
    idle(1, 1'b0);
    check_eq("t2_round_zero", int'(out_data), 0);
    idle(1, 1'b1);
    group(-129, 0, 1'b0, 2);
    idle(1, 1'b0);
    check_eq("t2_round_neg1", int'(out_data), 12'hFFF);
    idle(1, 1'b1);

    // Saturation at both rails.
    group(262143, 262143, 1'b0, 0);
    idle(1, 1'b0);
    check_eq("t3_pos_data", int'(out_data), 12'h7FF);
    check_eq("t3_pos_sat", int'(out_sat), 1);
    idle(1, 1'b1);
    group(-262144, -262144, 1'b0, 0);
    idle(1, 1'b0);
    check_eq("t3_neg_data", int'(out_data), 12'h800);
    check_eq("t3_neg_sat", int'(out_sat), 1);
    idle(1, 1'b1);

    // Backpressure: fifth word dropped, then push+pop while full.
    for (int g = 0; g < 5; g++) group(100 * g, 1000 * g, 1'b0, 0);
    idle(1, 1'b0);
    check_eq("t4_level_full", int'(fifo_level), 4);
    check_eq("t4_overflow", int'(overflow), 1);
    group(-5000, 7000, 1'b0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    check_eq("t4_level_pushpop", int'(fifo_level), 4);
    idle(6, 1'b1);
    check_eq("t4_drained", int'(fifo_level), 0);
    check_eq("t4_ovf_sticky", int'(overflow), 1);

    // clear mid-group drops the partial sum and the overflow flag.
    for (int i = 0; i < 3; i++) step(1'b1, 40000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 40000, 1'b0, 1'b1, 1'b0);
    check_eq("t5_ovf_cleared", int'(overflow), 0);
    group(100, 100, 1'b0, 0);
    idle(2, 1'b0);
    check_eq("t5_one_word", int'(fifo_level), 1);
    check_eq("t5_data", int'(out_data), 3);
    idle(2, 1'b1);

    // Reset while a word is queued and a group is half built.
    group(100, 100, 1'b0, 0);
    idle(1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 55555, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check_eq("t6_valid", int'(out_valid), 0);
    check_eq("t6_level", int'(fifo_level), 0);
    check_eq("t6_ovf", int'(overflow), 0);
    group(-3000, 2500, 1'b1, 0);
    idle(3, 1'b1);

    // Randomized traffic with alternating ready pressure.
    for (int i = 0; i < 4000; i++) begin
      bit pv, rdy, clr, rst;
      int pd;
      pv  = ($urandom_range(0, 3) != 0);
      pd  = int'($urandom_range(0, 524287)) - 262144;
      if (((i / 200) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
      else                      rdy = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(pv, pd, rdy, clr, rst);
    end
    idle(6, 1'b1);
    cmp_state();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
